// File: rtl/rstgen_seq.sv
// Reset sequencer: releases per-channel resets in a fixed order with a programmable gap,
// then the clock-gate reset and init flag; supports holds, software pulses and test-mode bypass.
module rstgen_seq #(
  parameter int NumChannels = 4,
  parameter int NumSyncRegs = 4,
  parameter int ReleaseGap  = 8,
  parameter int SwPulseLen  = 16,
  parameter int CntWidth    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   test_mode_i,
  input  logic                   rst_test_mode_ni,
  input  logic [NumChannels-1:0] ch_hold_i,
  input  logic [NumChannels-1:0] sw_rst_req_i,
  output logic [NumChannels-1:0] rst_no,
  output logic                   rst_ckg_no,
  output logic                   init_no,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int MaxCnt0 = (NumSyncRegs > ReleaseGap) ? NumSyncRegs : ReleaseGap;
  localparam int MaxCnt = (MaxCnt0 > SwPulseLen) ? MaxCnt0 : SwPulseLen;

  localparam logic [CntWidth-1:0] SyncLast = CntWidth'(NumSyncRegs);
  localparam logic [CntWidth-1:0] GapLast  = CntWidth'(ReleaseGap);
  localparam logic [CntWidth-1:0] PulseLen = CntWidth'(SwPulseLen);
  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
  localparam logic [IdxW-1:0]     LastIdx  = IdxW'(NumChannels - 1);

  if (NumChannels < 1 || NumChannels > 16) begin : g_bad_channels
    $fatal(1, "rstgen_seq: NumChannels must be 1..16");
  end
  if (NumSyncRegs < 1 || ReleaseGap < 1 || SwPulseLen < 1) begin : g_bad_timing
    $fatal(1, "rstgen_seq: NumSyncRegs, ReleaseGap and SwPulseLen must be >= 1");
  end
  if (CntWidth < 1 || CntWidth > 31 || (longint'(MaxCnt) >> CntWidth) != 0) begin : g_bad_cnt
    $fatal(1, "rstgen_seq: CntWidth too small for the configured counts");
  end

  typedef enum logic [2:0] {
    ST_RESET,
    ST_SYNC,
    ST_RELEASE,
    ST_CKG,
    ST_DONE
  } state_e;

  state_e                              state_q, state_d;
  logic [CntWidth-1:0]                 cnt_q, cnt_d;
  logic [IdxW-1:0]                     idx_q, idx_d;
  logic [NumChannels-1:0]              rst_q, rst_d;
  logic                                ckg_q, ckg_d;
  logic                                init_q, init_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic [NumChannels-1:0][CntWidth-1:0] pcnt_q, pcnt_d;

  logic                   rel_fire;
  logic [IdxW-1:0]        rel_idx;
  logic [NumChannels-1:0] pulsing;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rst_d    = rst_q;
    ckg_d    = ckg_q;
    init_d   = init_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pcnt_d   = pcnt_q;
    rel_fire = 1'b0;
    rel_idx  = idx_q;
    pulsing  = '0;

    case (state_q)
      ST_RESET: begin
        // The edge leaving RESET is the first settle cycle.
        state_d = ST_SYNC;
        cnt_d   = CntOne;
        busy_d  = 1'b1;
      end
      ST_SYNC: begin
        if (cnt_q == SyncLast) begin
          if (ch_hold_i[0]) begin
            // Park in RELEASE with the slot already reached so the hold is polled each edge.
            state_d = ST_RELEASE;
            idx_d   = '0;
            cnt_d   = GapLast;
          end else begin
            rel_fire = 1'b1;
            rel_idx  = '0;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == GapLast) begin
          if (!ch_hold_i[idx_q]) begin
            rel_fire = 1'b1;
            rel_idx  = idx_q;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      ST_CKG: begin
        if (cnt_q == GapLast) begin
          state_d = ST_DONE;
          ckg_d   = 1'b1;
          init_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      ST_DONE: begin
        for (int k = 0; k < NumChannels; k++) begin
          if (sw_rst_req_i[k]) begin
            pcnt_d[k] = PulseLen;
          end else if (pcnt_q[k] != '0) begin
            pcnt_d[k] = pcnt_q[k] - CntOne;
          end
          pulsing[k] = (pcnt_d[k] != '0);
          rst_d[k]   = ~pulsing[k];
        end
        busy_d = |pulsing;
      end
      default: state_d = ST_RESET;
    endcase

    if (rel_fire) begin
      rst_d[rel_idx] = 1'b1;
      cnt_d          = CntOne;
      if (rel_idx == LastIdx) begin
        state_d = ST_CKG;
      end else begin
        state_d = ST_RELEASE;
        idx_d   = rel_idx + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      ckg_q   <= 1'b0;
      init_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ckg_q   <= ckg_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Test mode overrides the reset outputs only; the sequencer keeps running underneath.
  assign rst_no     = test_mode_i ? {NumChannels{rst_test_mode_ni}} : rst_q;
  assign rst_ckg_no = test_mode_i ? rst_test_mode_ni : ckg_q;
  assign init_no    = test_mode_i ? 1'b1 : init_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_rstgen_seq.sv
// Directed bench for rstgen_seq: a default instance plus a minimal 1-channel instance,
// expected per-cycle outputs queued by the driver and checked by a negedge monitor.
module tb_rstgen_seq;

  logic       clk = 1'b0;
  logic       rst_i, test_mode_i, rst_test_mode_ni;
  logic [3:0] ch_hold_i, sw_rst_req_i, rst_no;
  logic       rst_ckg_no, init_no, busy_o, done_o;

  logic s_tm, s_tmn, s_hold, s_req;
  logic s_rst_no, s_ckg, s_init, s_busy, s_done;

  logic [7:0] exp_q[$];
  logic [4:0] exp_s_q[$];

  int vectors = 0;
  int miscompares = 0;
  int e = 0;
  int e0 = 0;
  bit in_rst = 1'b1;
  int rel[4];
  int ck_e;
  logic [3:0] sw_low = 4'b0000;

  always #5 clk = ~clk;

  rstgen_seq u_dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .test_mode_i     (test_mode_i),
    .rst_test_mode_ni(rst_test_mode_ni),
    .ch_hold_i       (ch_hold_i),
    .sw_rst_req_i    (sw_rst_req_i),
    .rst_no          (rst_no),
    .rst_ckg_no      (rst_ckg_no),
    .init_no         (init_no),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  rstgen_seq #(
    .NumChannels(1),
    .NumSyncRegs(1),
    .ReleaseGap (1),
    .SwPulseLen (3),
    .CntWidth   (4)
  ) u_small (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .test_mode_i     (s_tm),
    .rst_test_mode_ni(s_tmn),
    .ch_hold_i       (s_hold),
    .sw_rst_req_i    (s_req),
    .rst_no          (s_rst_no),
    .rst_ckg_no      (s_ckg),
    .init_no         (s_init),
    .busy_o          (s_busy),
    .done_o          (s_done)
  );

  task automatic set_rel(input int r0, input int r1, input int r2, input int r3, input int ck);
    rel[0] = r0; rel[1] = r1; rel[2] = r2; rel[3] = r3; ck_e = ck;
  endtask

  // Advance one edge and track E0 from the rst_i value the DUT sampled there.
  task automatic tick();
    @(posedge clk);
    e++;
    if (rst_i) in_rst = 1'b1;
    else if (in_rst) begin
      in_rst = 1'b0;
      e0 = e;
    end
    #1;
  endtask

  function automatic logic [7:0] model();
    logic [3:0] r;
    logic ckg, ini, bsy, dn;
    int d;
    d = e - e0;
    if (in_rst) begin
      r = 4'b0000; ckg = 1'b0; ini = 1'b0; bsy = 1'b1; dn = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) r[k] = (d >= rel[k]);
      dn  = (d >= ck_e);
      ckg = dn;
      ini = dn;
      bsy = !dn || (sw_low != 4'b0000);
      r   = r & ~sw_low;
    end
    if (test_mode_i) begin
      r = {4{rst_test_mode_ni}}; ckg = rst_test_mode_ni; ini = 1'b1;
    end
    return {r, ckg, ini, bsy, dn};
  endfunction

  function automatic logic [4:0] model_s();
    int d;
    logic dn;
    d = e - e0;
    if (in_rst) return 5'b00010;
    dn = (d >= 2);
    return {(d >= 1), dn, dn, !dn, dn};
  endfunction

  task automatic push();
    exp_q.push_back(model());
    exp_s_q.push_back(model_s());
  endtask

  task automatic step();
    tick();
    push();
  endtask

  always @(negedge clk) begin
    logic [7:0] ev, av;
    logic [4:0] evs, avs;
    if (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      av = {rst_no, rst_ckg_no, init_no, busy_o, done_o};
      vectors++;
      if (av !== ev) begin
        miscompares++;
        $display("FAIL main edge=%0d {rst_no,ckg,init,busy,done} got=%b want=%b", e, av, ev);
      end
    end
    if (exp_s_q.size() > 0) begin
      evs = exp_s_q.pop_front();
      avs = {s_rst_no, s_ckg, s_init, s_busy, s_done};
      vectors++;
      if (avs !== evs) begin
        miscompares++;
        $display("FAIL small edge=%0d {rst_no,ckg,init,busy,done} got=%b want=%b", e, avs, evs);
      end
    end
  end

  initial begin
    rst_i = 1'b1; test_mode_i = 1'b0; rst_test_mode_ni = 1'b1;
    ch_hold_i = 4'b0000; sw_rst_req_i = 4'b0000;
    s_tm = 1'b0; s_tmn = 1'b1; s_hold = 1'b0; s_req = 1'b0;

    // Plain sequence; sw requests during SYNC and CKG must be ignored.
    set_rel(4, 12, 20, 28, 36);
    repeat (3) step();
    rst_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sw_rst_req_i = (i == 2 || i == 30) ? 4'b1111 : 4'b0000;
      step();
    end
    sw_rst_req_i = 4'b0000;

    // Hold on channel 2 until sampled low at E0+25; hold on released channel 0 is ignored.
    rst_i = 1'b1;
    repeat (2) step();
    set_rel(4, 12, 25, 33, 41);
    ch_hold_i = 4'b0100;
    rst_i = 1'b0;
    for (int i = 0; i < 46; i++) begin
      step();
      if (i == 5) ch_hold_i[0] = 1'b1;
      if (i == 24) ch_hold_i[2] = 1'b0;
    end
    ch_hold_i = 4'b0000;

    // Software pulses in DONE: channels 0 and 2, then a restart on channel 0.
    for (int j = 0; j < 26; j++) begin
      sw_rst_req_i = (j == 0) ? 4'b0101 : (j == 5) ? 4'b0001 : 4'b0000;
      tick();
      sw_rst_req_i = 4'b0000;
      sw_low[0] = (j <= 20);
      sw_low[2] = (j <= 15);
      push();
    end
    sw_low = 4'b0000;

    // Reset mid-release at E0+15, then a full restart.
    rst_i = 1'b1;
    repeat (2) step();
    set_rel(4, 12, 20, 28, 36);
    rst_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (i == 14) rst_i = 1'b1;
    end
    repeat (3) step();
    rst_i = 1'b0;
    for (int i = 0; i < 40; i++) step();

    // Test-mode bypass through RESET and SYNC, then released back to the sequencer.
    rst_i = 1'b1;
    test_mode_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      rst_test_mode_ni = i[0];
      push();
    end
    rst_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i < 6) rst_test_mode_ni = ~rst_test_mode_ni;
      if (i == 6) test_mode_i = 1'b0;
      push();
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0 || exp_s_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain leftover=%0d want=0", exp_q.size() + exp_s_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
